// File: rtl/device_sel_pkg.sv
// Shared types and round-robin helpers for the display-owner arbiter.
// Latency: combinational helpers only.
// Backpressure: none.
package device_sel_pkg;

    typedef enum logic [1:0] {
        SEL_DEFAULT = 2'b00,
        SEL_NES     = 2'b01,
        SEL_PS2     = 2'b10,
        SEL_VCR     = 2'b11
    } device_sel_t;

    localparam int N_DEV = 3;

    // First requesting device found scanning from device index ptr (0=NES, 1=PS2, 2=VCR).
    function automatic device_sel_t rr_next(input logic [2:0] req, input logic [1:0] ptr);
        device_sel_t sel;
        logic [2:0]  pos;
        logic        found;
        sel   = SEL_DEFAULT;
        found = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            pos = {1'b0, ptr} + 3'(i);
            if (pos >= 3'd3) begin
                pos = pos - 3'd3;
            end
            if (!found && req[pos]) begin
                found = 1'b1;
                sel   = device_sel_t'(2'(pos[1:0] + 2'd1));
            end
        end
        return sel;
    endfunction

    // One-hot request/pending bit for a selection; SEL_DEFAULT maps to no bit.
    function automatic logic [2:0] sel_mask(input device_sel_t sel);
        logic [2:0] m;
        case (sel)
            SEL_NES: m = 3'b001;
            SEL_PS2: m = 3'b010;
            SEL_VCR: m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Idle countdown for the current display owner; expires when the count reaches zero.
// Latency: load/decrement visible one cycle after the control edge.
// Backpressure: none; load wins over decrement, count saturates at zero.
module hold_timer #(
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYCLES - 1);

    logic [TW-1:0] count;

    // Reload on owner activity, otherwise count down and stick at zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count <= '0;
        end else if (i_load) begin
            count <= RELOAD;
        end else if (i_en && (count != '0)) begin
            count <= count - TW'(1);
        end
    end

    assign o_expired = (count == '0);

endmodule

// File: rtl/device_select_arbiter.sv
// Grants LED/7-seg display ownership to one of NES/PS2/VCR by activity, round-robin.
// Latency: 1 cycle from sampled activity to o_sel; handover on expiry is a single edge.
// Backpressure: owner never preempted; other requests latch into o_pending until served.
module device_select_arbiter
    import device_sel_pkg::*;
#(
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [2:0] i_act,
    input  logic       i_manual,
    input  logic [1:0] i_sel_man,
    output logic [1:0] o_sel,
    output logic       o_busy,
    output logic [2:0] o_pending
);

    device_sel_t state;
    logic [1:0]  rr_ptr;

    logic [2:0]  own_mask;
    logic [2:0]  req_all;
    logic [2:0]  req_other;
    logic        owner_active;
    logic        timer_expired;
    logic        release_now;
    logic [1:0]  own_idx;
    logic [1:0]  after_idx;
    device_sel_t grant_sel;
    logic        timer_load;
    logic        timer_en;
    logic        timer_clr;

    assign own_mask     = sel_mask(state);
    assign req_all      = o_pending | i_act;
    assign req_other    = req_all & ~own_mask;
    assign owner_active = |(i_act & own_mask);
    assign release_now  = (state != SEL_DEFAULT) && !owner_active && timer_expired;
    assign own_idx      = 2'(state) - 2'd1;
    assign after_idx    = (own_idx == 2'd2) ? 2'd0 : own_idx + 2'd1;

    // Pick the next owner: from rr_ptr when idle, from just after the owner on release.
    always_comb begin
        grant_sel = SEL_DEFAULT;
        if (state == SEL_DEFAULT) begin
            grant_sel = rr_next(req_all, rr_ptr);
        end else if (release_now) begin
            grant_sel = rr_next(req_other, after_idx);
        end
    end

    // Manual mode parks the timer at zero; any new grant or owner activity reloads it.
    assign timer_clr  = i_reset | i_manual;
    assign timer_load = !i_manual && ((grant_sel != SEL_DEFAULT) || owner_active);
    assign timer_en   = !i_manual && (state != SEL_DEFAULT) && !owner_active;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .i_clk    (i_clk),
        .i_reset  (timer_clr),
        .i_load   (timer_load),
        .i_en     (timer_en),
        .o_expired(timer_expired)
    );

    // Ownership FSM with registered select/busy/pending outputs and round-robin pointer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= SEL_DEFAULT;
            o_sel     <= 2'b00;
            o_busy    <= 1'b0;
            o_pending <= 3'b000;
            rr_ptr    <= 2'd0;
        end else if (i_manual) begin
            state     <= SEL_DEFAULT;
            o_sel     <= i_sel_man;
            o_busy    <= 1'b0;
            o_pending <= 3'b000;
        end else if (state == SEL_DEFAULT) begin
            state     <= grant_sel;
            o_sel     <= grant_sel;
            o_busy    <= (grant_sel != SEL_DEFAULT);
            o_pending <= req_all & ~sel_mask(grant_sel);
        end else if (release_now) begin
            rr_ptr    <= after_idx;
            state     <= grant_sel;
            o_sel     <= grant_sel;
            o_busy    <= (grant_sel != SEL_DEFAULT);
            o_pending <= req_other & ~sel_mask(grant_sel);
        end else begin
            o_pending <= req_other;
        end
    end

endmodule

// File: tb/tb_device_select_arbiter.sv
// Directed bench for device_select_arbiter with a short hold time.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_device_select_arbiter;

    localparam int HOLD = 8;

    logic       clk;
    logic       rst;
    logic [2:0] act;
    logic       man;
    logic [1:0] sel_man;
    logic [1:0] sel;
    logic       busy;
    logic [2:0] pend;

    int checks   = 0;
    int failures = 0;

    device_select_arbiter #(
        .HOLD_CYCLES(HOLD)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_act    (act),
        .i_manual (man),
        .i_sel_man(sel_man),
        .o_sel    (sel),
        .o_busy   (busy),
        .o_pending(pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] act;
        logic       man;
        logic [1:0] sm;
        logic [1:0] esel;
        logic       ebusy;
        logic [2:0] epend;
    } vec_t;

    vec_t vecs[$];

    task automatic add_rows(input int n, input string name, input logic r, input logic [2:0] a,
                            input logic m, input logic [1:0] s, input logic [1:0] es,
                            input logic eb, input logic [2:0] ep);
        vec_t v;
        v.name = name; v.rst = r; v.act = a; v.man = m; v.sm = s;
        v.esel = es; v.ebusy = eb; v.epend = ep;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, clock it, then compare all outputs.
    task automatic step(input string name, input logic r, input logic [2:0] a, input logic m,
                        input logic [1:0] s, input logic [1:0] es, input logic eb,
                        input logic [2:0] ep);
        rst = r; act = a; man = m; sel_man = s;
        @(posedge clk);
        #1;
        checks++;
        if (sel !== es || busy !== eb || pend !== ep) begin
            failures++;
            $display("FAIL %s t=%0t: got sel=%b busy=%b pend=%b, want sel=%b busy=%b pend=%b",
                     name, $time, sel, busy, pend, es, eb, ep);
        end
    endtask

    initial begin
        rst = 1'b1; act = 3'b000; man = 1'b0; sel_man = 2'b00;

        // Reset with activity, single PS2 grant/expiry, then three-way request chain.
        add_rows(2, "t1_reset",      1, 3'b001, 0, 2'b00, 2'b00, 0, 3'b000);
        add_rows(1, "t1_idle",       0, 3'b000, 0, 2'b00, 2'b00, 0, 3'b000);
        add_rows(1, "t2_grant",      0, 3'b010, 0, 2'b00, 2'b10, 1, 3'b000);
        add_rows(7, "t2_hold",       0, 3'b000, 0, 2'b00, 2'b10, 1, 3'b000);
        add_rows(1, "t2_release",    0, 3'b000, 0, 2'b00, 2'b00, 0, 3'b000);
        add_rows(1, "t3_rst",        1, 3'b000, 0, 2'b00, 2'b00, 0, 3'b000);
        add_rows(1, "t3_grant_nes",  0, 3'b111, 0, 2'b00, 2'b01, 1, 3'b110);
        add_rows(7, "t3_hold_nes",   0, 3'b000, 0, 2'b00, 2'b01, 1, 3'b110);
        add_rows(1, "t3_hand_ps2",   0, 3'b000, 0, 2'b00, 2'b10, 1, 3'b100);
        add_rows(7, "t3_hold_ps2",   0, 3'b000, 0, 2'b00, 2'b10, 1, 3'b100);
        add_rows(1, "t3_hand_vcr",   0, 3'b000, 0, 2'b00, 2'b11, 1, 3'b000);
        add_rows(7, "t3_hold_vcr",   0, 3'b000, 0, 2'b00, 2'b11, 1, 3'b000);
        add_rows(1, "t3_idle",       0, 3'b000, 0, 2'b00, 2'b00, 0, 3'b000);

        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].rst, vecs[i].act, vecs[i].man, vecs[i].sm,
                 vecs[i].esel, vecs[i].ebusy, vecs[i].epend);
        end

        // NES kept alive by pulses every 5 cycles; VCR request latched mid-way.
        step("t4_grant", 0, 3'b001, 0, 2'b00, 2'b01, 1, 3'b000);
        for (int c = 1; c <= 40; c++) begin
            logic [2:0] a;
            a = (c % 5 == 0) ? 3'b001 : 3'b000;
            if (c == 17) a = a | 3'b100;
            step("t4_keep", 0, a, 0, 2'b00, 2'b01, 1, (c >= 17) ? 3'b100 : 3'b000);
        end
        for (int c = 0; c < 7; c++) step("t4_tail", 0, 3'b000, 0, 2'b00, 2'b01, 1, 3'b100);
        step("t4_vcr", 0, 3'b000, 0, 2'b00, 2'b11, 1, 3'b000);
        for (int c = 0; c < 7; c++) step("t4_vcr_hold", 0, 3'b000, 0, 2'b00, 2'b11, 1, 3'b000);
        step("t4_idle", 0, 3'b000, 0, 2'b00, 2'b00, 0, 3'b000);

        // Manual override mid-grant, then arbitration resumes.
        step("t5_ps2",        0, 3'b010, 0, 2'b00, 2'b10, 1, 3'b000);
        step("t5_pend_nes",   0, 3'b001, 0, 2'b00, 2'b10, 1, 3'b001);
        step("t5_manual",     0, 3'b000, 1, 2'b11, 2'b11, 0, 3'b000);
        step("t5_manual_ign", 0, 3'b111, 1, 2'b11, 2'b11, 0, 3'b000);
        step("t5_resume",     0, 3'b000, 0, 2'b00, 2'b00, 0, 3'b000);
        step("t5_vcr",        0, 3'b100, 0, 2'b00, 2'b11, 1, 3'b000);
        for (int c = 0; c < 7; c++) step("t5_hold", 0, 3'b000, 0, 2'b00, 2'b11, 1, 3'b000);
        step("t5_idle", 0, 3'b000, 0, 2'b00, 2'b00, 0, 3'b000);

        // Move rr_ptr to VCR, reset mid VCR grant, confirm pointer returns to NES.
        step("t6_ps2", 0, 3'b010, 0, 2'b00, 2'b10, 1, 3'b000);
        for (int c = 0; c < 7; c++) step("t6_ps2_hold", 0, 3'b000, 0, 2'b00, 2'b10, 1, 3'b000);
        step("t6_ps2_rel", 0, 3'b000, 0, 2'b00, 2'b00, 0, 3'b000);
        step("t6_vcr", 0, 3'b100, 0, 2'b00, 2'b11, 1, 3'b000);
        for (int c = 0; c < 4; c++) step("t6_vcr_hold", 0, 3'b000, 0, 2'b00, 2'b11, 1, 3'b000);
        step("t6_reset", 1, 3'b000, 0, 2'b00, 2'b00, 0, 3'b000);
        step("t6_rr_nes", 0, 3'b111, 0, 2'b00, 2'b01, 1, 3'b110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
